reset_request_arbiter: RTL
==========================

# reset_request_arbiter

Collects reset requests from several system sources (watchdog, software register, debug port, power monitor) and sequences the single `sync_rst_Trigger` input of the top-level reset/flag generator. It picks one winning requester by fixed priority and filters glitches with a hold-off window. It then drives a bounded trigger pulse, waits for the generator's init pulse (with timeout), and enforces a cooldown before accepting the next request. The winning requester is latched as a sticky reset cause for software.

## Interface
Parameters:
- `REQUESTERS`, 4: number of request sources; legal range 1–16; index 0 has highest priority.
- `HOLDOFFCYCLES`, 16: enabled cycles a request must stay continuously asserted before triggering; minimum 1.
- `TRIGGERCYCLES`, 4: enabled cycles `sync_rst_Trigger` is held high; minimum 1.
- `INITTIMEOUTCYCLES`, 1048576: enabled cycles to wait for `InitIn` before declaring a timeout; minimum 1.
- `COOLDOWNCYCLES`, 1024: enabled cycles of post-reset lockout; minimum 1.

Ports:
- `clk`, in, 1: system clock.
- `async_rst_n`, in, 1: asynchronous, active-low reset.
- `clk_en`, in, 1: clock enable; all state holds when low.
- `ReqIn`, in, REQUESTERS: level reset requests; bit i comes from source i.
- `ReqMask`, in, REQUESTERS: 1 masks (ignores) the corresponding request.
- `InitIn`, in, 1: init pulse from the reset/flag generator.
- `CauseClear`, in, 1: clears the sticky cause and timeout flags.
- `sync_rst_Trigger`, out, 1: registered reset trigger to the flag generator.
- `Busy`, out, 1: high whenever the state is not IDLE.
- `CauseValid`, out, 1: sticky; a reset has been issued since the last clear.
- `CauseIndex`, out, max(1,$clog2(REQUESTERS)): index of the last winning requester.
- `TimeoutFlag`, out, 1: sticky; `InitIn` was not seen within the timeout window.
- `CountIndex`, in, same width as `CauseIndex`: counter select; present only with the macro.
- `CountOut`, out, 8: selected reset counter; present only with the macro.

## Operation
- `Active = ReqIn & ~ReqMask`. `Winner` is the lowest set index of `Active`.
- FSM states: IDLE, ARM, TRIGGER, WAIT_INIT, COOLDOWN. One shared counter has width $clog2(max parameter + 1). The counter clears on every state entry and increments only on `clk_en` cycles.
- IDLE → ARM when `|Active` and `clk_en`. `Winner` is latched into `PendIdx`.
- ARM:
  - If `Active[PendIdx]` drops, return to IDLE. This is the glitch filter; there is no re-arbitration.
  - Otherwise, at count == HOLDOFFCYCLES-1, go to TRIGGER. On that same edge, `CauseIndex` ← `PendIdx` and `CauseValid` ← 1.
- TRIGGER: `sync_rst_Trigger` = 1. At count == TRIGGERCYCLES-1, go to WAIT_INIT.
- WAIT_INIT:
  - `InitIn` && `clk_en` → COOLDOWN.
  - Else, at count == INITTIMEOUTCYCLES-1 → COOLDOWN and `TimeoutFlag` ← 1.
  - `InitIn` wins if it coincides with the timeout.
- COOLDOWN: at count == COOLDOWNCYCLES-1 → IDLE. Requests are ignored in COOLDOWN. A request still held is re-arbitrated in IDLE.
- `InitIn` outside WAIT_INIT is ignored.
- `CauseClear` && `clk_en` clears `CauseValid` and `TimeoutFlag`. A simultaneous set (TRIGGER entry or timeout) wins over the clear. `CauseIndex` is never cleared except by reset.
- `ReqMask` changes take effect on the next enabled cycle. In ARM, masking the pending source counts as the request dropping.

## Timing
- Reset values: state IDLE, counter 0, `sync_rst_Trigger` 0, `Busy` 0, `CauseValid` 0, `CauseIndex` 0, `TimeoutFlag` 0, all counters 0.
- Reset is asserted asynchronously. It is released synchronously to `clk` by the upstream synchronizer.
- With `clk_en` held at 1: request sampled high at edge N → ARM after N. `sync_rst_Trigger` rises after edge N+HOLDOFFCYCLES and stays high for exactly TRIGGERCYCLES cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output. When the macro is enabled, `CountOut` is a mux on `CountIndex`.
- Cycles with `clk_en`=0 stretch every window. The outputs hold their values during those cycles.
- `async_rst_n` asserted mid-sequence drops `sync_rst_Trigger` immediately and returns to IDLE.

## Configuration
- `RSTARB_CAUSE_COUNT_EN`:
  - When defined: one 8-bit saturating counter per requester. A counter increments on TRIGGER entry for its `PendIdx` and sticks at 255. `CauseClear` zeroes all counters; increment wins on a coincident clear of the same counter. `CountOut` = counter[`CountIndex`]; an out-of-range index reads 0.
  - When undefined: `CountIndex` and `CountOut` and all counter logic are absent.

## Test plan
- Parameters REQUESTERS=4, HOLDOFFCYCLES=4, TRIGGERCYCLES=2, COOLDOWNCYCLES=8; hold `ReqIn`=4'b0100 → `sync_rst_Trigger` high for exactly 2 cycles, starting 4 cycles after the request is sampled; `CauseIndex`=2, `CauseValid`=1.
- `ReqIn`=4'b1010 asserted together → winner is index 1; `CauseIndex`=1.
- `ReqIn[0]` pulsed for 2 cycles with HOLDOFFCYCLES=4 → return to IDLE with no trigger; `CauseValid` stays 0.
- `InitIn` never arrives, INITTIMEOUTCYCLES=16 → `TimeoutFlag`=1 on the 16th WAIT_INIT cycle; then COOLDOWN, then IDLE; `CauseClear` then clears both flags.
- Request held through COOLDOWN; `async_rst_n` pulsed low during TRIGGER → `sync_rst_Trigger` drops immediately, all outputs return to reset values, and the held request is re-triggered after HOLDOFFCYCLES.
- With `RSTARB_CAUSE_COUNT_EN`: 300 resets from source 3 → `CountOut`=255 for `CountIndex`=3, and 0 for the other indices.

Source files
------------

// File: rtl/reset_request_arbiter.sv
// Fixed-priority reset request arbiter: hold-off glitch filter, bounded trigger pulse, init wait with timeout, cooldown.
// Optional per-source saturating reset counters are enabled by defining RSTARB_CAUSE_COUNT_EN.
module reset_request_arbiter #(
    parameter int REQUESTERS        = 4,
    parameter int HOLDOFFCYCLES     = 16,
    parameter int TRIGGERCYCLES     = 4,
    parameter int INITTIMEOUTCYCLES = 1048576,
    parameter int COOLDOWNCYCLES    = 1024,
    localparam int IDX_W            = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  clk_en,
    input  logic [REQUESTERS-1:0] ReqIn,
    input  logic [REQUESTERS-1:0] ReqMask,
    input  logic                  InitIn,
    input  logic                  CauseClear,
    output logic                  sync_rst_Trigger,
    output logic                  Busy,
    output logic                  CauseValid,
    output logic [IDX_W-1:0]      CauseIndex,
    output logic                  TimeoutFlag
`ifdef RSTARB_CAUSE_COUNT_EN
    ,
    input  logic [IDX_W-1:0]      CountIndex,
    output logic [7:0]            CountOut
`endif
);

    localparam int MAX_HT  = (HOLDOFFCYCLES > TRIGGERCYCLES) ? HOLDOFFCYCLES : TRIGGERCYCLES;
    localparam int MAX_IC  = (INITTIMEOUTCYCLES > COOLDOWNCYCLES) ? INITTIMEOUTCYCLES : COOLDOWNCYCLES;
    localparam int MAX_ALL = (MAX_HT > MAX_IC) ? MAX_HT : MAX_IC;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int EXT_N   = 2 ** IDX_W;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFFCYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIGGERCYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(INITTIMEOUTCYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWNCYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        TRIGGER,
        WAIT_INIT,
        COOLDOWN
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        pend_idx_q, pend_idx_d;
    logic [IDX_W-1:0]        cause_idx_q, cause_idx_d;
    logic                    cause_valid_q, cause_valid_d;
    logic                    timeout_q, timeout_d;

    logic [REQUESTERS-1:0]   active;
    logic [EXT_N-1:0]        active_ext;
    logic [IDX_W-1:0]        winner;
    logic                    enter_trigger;
    logic                    set_timeout;
    logic                    clear_now;

    assign active    = ReqIn & ~ReqMask;
    assign clear_now = clk_en & CauseClear;

    // Zero-extended copy so the pending index can address it for any REQUESTERS value.
    always_comb begin
        active_ext                   = '0;
        active_ext[REQUESTERS-1:0]   = active;
    end

    always_comb begin
        winner = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_idx_d    = pend_idx_q;
        enter_trigger = 1'b0;
        set_timeout   = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (|active) begin
                        state_d    = ARM;
                        pend_idx_d = winner;
                    end
                end
                ARM: begin
                    if (!active_ext[pend_idx_q]) begin
                        state_d = IDLE;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d       = TRIGGER;
                        enter_trigger = 1'b1;
                    end
                end
                TRIGGER: begin
                    if (cnt_q == TRIG_LAST) begin
                        state_d = WAIT_INIT;
                    end
                end
                WAIT_INIT: begin
                    if (InitIn) begin
                        state_d = COOLDOWN;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = COOLDOWN;
                        set_timeout = 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // The shared window counter restarts on every state entry and never runs in IDLE.
            if ((state_d != state_q) || (state_q == IDLE)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A flag being set on the same cycle as a software clear takes precedence.
    always_comb begin
        cause_valid_d = cause_valid_q;
        timeout_d     = timeout_q;
        cause_idx_d   = cause_idx_q;
        if (clear_now) begin
            cause_valid_d = 1'b0;
            timeout_d     = 1'b0;
        end
        if (enter_trigger) begin
            cause_valid_d = 1'b1;
            cause_idx_d   = pend_idx_q;
        end
        if (set_timeout) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_idx_q    <= '0;
            cause_idx_q   <= '0;
            cause_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_idx_q    <= pend_idx_d;
            cause_idx_q   <= cause_idx_d;
            cause_valid_q <= cause_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign sync_rst_Trigger = (state_q == TRIGGER);
    assign Busy             = (state_q != IDLE);
    assign CauseValid       = cause_valid_q;
    assign CauseIndex       = cause_idx_q;
    assign TimeoutFlag      = timeout_q;

`ifdef RSTARB_CAUSE_COUNT_EN
    logic [7:0] cause_cnt_q [REQUESTERS];
    logic [7:0] cause_cnt_d [REQUESTERS];

    // An increment on the same cycle as a clear is applied to the pre-clear value.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            cause_cnt_d[i] = cause_cnt_q[i];
            if (clear_now) begin
                cause_cnt_d[i] = 8'd0;
            end
            if (enter_trigger && (pend_idx_q == IDX_W'(i))) begin
                cause_cnt_d[i] = (cause_cnt_q[i] == 8'hFF) ? 8'hFF : (cause_cnt_q[i] + 8'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                cause_cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                cause_cnt_q[i] <= cause_cnt_d[i];
            end
        end
    end

    always_comb begin
        CountOut = 8'd0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (CountIndex == IDX_W'(i)) begin
                CountOut = cause_cnt_q[i];
            end
        end
    end
`endif

endmodule
